alu_mdu: RTL

//   Iterative RV32M multiply/divide unit, sitting beside the single-cycle ALU in the execute stage.

---
 rtl/alu_mdu.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// Iterative radix-2 RV32M multiply/divide unit with Start/Busy/Done handshake.
// Optional MDU_FAST_PATH_EN: divide-by-zero and signed overflow skip the iteration loop.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDUControl,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [2:0]       op_q, op_n;
  logic [WIDTH-1:0] ma_q, ma_n, mb_q, mb_n;
  logic [WIDTH-1:0] hi_q, hi_n, lo_q, lo_n;
  logic             negq_q, negq_n, negr_q, negr_n;
  logic             dz_q, dz_n, ovf_q, ovf_n;
  logic [WIDTH-1:0] res_q, res_n;

  // operand decode at accept time
  logic             a_sgn, b_sgn, a_neg, b_neg, is_div, dz_in, ovf_in;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    is_div = MDUControl[2];
    a_sgn  = is_div ? ~MDUControl[0] : (MDUControl[1:0] != 2'b11);
    b_sgn  = is_div ? ~MDUControl[0] : (MDUControl[1:0] <= 2'b01);
    a_neg  = a_sgn & A[WIDTH-1];
    b_neg  = b_sgn & B[WIDTH-1];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    dz_in  = is_div & (B == '0);
    ovf_in = is_div & ~MDUControl[0] & (A == MINV) & (B == '1);
  end

  // one iteration: hi:lo is the product accumulator or remainder:quotient pair
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum, sh, dif;
  logic             ge;
  logic [WIDTH-1:0] it_hi, it_lo;

  always_comb begin
    addend = lo_q[0] ? ma_q : '0;
    sum    = {1'b0, hi_q} + {1'b0, addend};
    sh     = {hi_q, lo_q[WIDTH-1]};
    dif    = sh - {1'b0, mb_q};
    ge     = (sh >= {1'b0, mb_q});
    if (op_q[2]) begin
      it_hi = ge ? dif[WIDTH-1:0] : sh[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      it_hi = sum[WIDTH:1];
      it_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // final sign fix and RISC-V boundary values
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fin;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = negq_q ? -prod : prod;
    quo_s  = negq_q ? -lo_q : lo_q;
    rem_s  = negr_q ? -hi_q : hi_q;
    fin    = '0;
    if (!op_q[2]) begin
      fin = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end else if (dz_q) begin
      fin = op_q[1] ? (negr_q ? -ma_q : ma_q) : '1;
    end else if (ovf_q) begin
      fin = op_q[1] ? '0 : MINV;
    end else begin
      fin = op_q[1] ? rem_s : quo_s;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    op_n    = op_q;
    ma_n    = ma_q;
    mb_n    = mb_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    negq_n  = negq_q;
    negr_n  = negr_q;
    dz_n    = dz_q;
    ovf_n   = ovf_q;
    res_n   = res_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_n = CALC;
          op_n    = MDUControl;
          ma_n    = a_mag;
          mb_n    = is_div ? b_mag : b_mag;
          hi_n    = '0;
          lo_n    = is_div ? a_mag : b_mag;
          negq_n  = a_neg ^ b_neg;
          negr_n  = a_neg;
          dz_n    = dz_in;
          ovf_n   = ovf_in;
`ifdef MDU_FAST_PATH_EN
          cnt_n   = (dz_in | ovf_in) ? '0 : CW'(WIDTH);
`else
          cnt_n   = CW'(WIDTH);
`endif
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          hi_n  = it_hi;
          lo_n  = it_lo;
          cnt_n = cnt_q - CW'(1);
        end else begin
          res_n   = fin;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      op_q    <= op_n;
      ma_q    <= ma_n;
      mb_q    <= mb_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      negq_q  <= negq_n;
      negr_q  <= negr_n;
      dz_q    <= dz_n;
      ovf_q   <= ovf_n;
      res_q   <= res_n;
    end
  end

  assign Busy   = (state_q != IDLE);
  assign Done   = (state_q == DONE);
  assign Result = res_q;

endmodule
